// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator: pixel/line counters, sync and
// visible-region decode with an optional pixel-enable delay line on the decode.
module vga_timing_gen #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int          SYNC_DELAY = 1,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned ROW_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pixEn,
    input  logic             run,
    output logic             hSync,
    output logic             vSync,
    output logic             displayActive,
    output logic [COL_W-1:0] column,
    output logic [ROW_W-1:0] row,
    output logic             lineStart,
    output logic             frameStart,
    output logic [7:0]       frameCount
);

    localparam int HT           = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT           = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic [COL_W-1:0] h_count;
    logic [ROW_W-1:0] v_count;
    logic             h_last;
    logic             v_last;
    logic             at_origin;
    logic [2:0]       dec;

    // Decode kept active-high as {hs, vs, active}; polarity applied at the pins.
    logic [SYNC_DELAY:0][2:0] pipe;
    logic [SYNC_DELAY:0][2:0] pipe_next;

    always_comb begin
        h_last    = (int'(h_count) == HT - 1);
        v_last    = (int'(v_count) == VT - 1);
        at_origin = (h_count == '0) && (v_count == '0);
        dec[2]    = (int'(h_count) >= H_SYNC_START) && (int'(h_count) < H_SYNC_END);
        dec[1]    = (int'(v_count) >= V_SYNC_START) && (int'(v_count) < V_SYNC_END);
        dec[0]    = (int'(h_count) < H_ACTIVE) && (int'(v_count) < V_ACTIVE);
    end

    generate
        if (SYNC_DELAY > 0) begin : g_delay
            assign pipe_next = {pipe[SYNC_DELAY-1:0], dec};
        end else begin : g_no_delay
            assign pipe_next = dec;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_count    <= '0;
            v_count    <= '0;
            column     <= '0;
            row        <= '0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            frameCount <= 8'd0;
            pipe       <= '0;
        end else if (!run) begin
            // Idle clears everything except the frame tally.
            h_count    <= '0;
            v_count    <= '0;
            column     <= '0;
            row        <= '0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            pipe       <= '0;
        end else if (pixEn) begin
            column     <= h_count;
            row        <= v_count;
            lineStart  <= (h_count == '0);
            frameStart <= at_origin;
            if (at_origin) begin
                frameCount <= frameCount + 8'd1;
            end
            pipe <= pipe_next;
            if (h_last) begin
                h_count <= '0;
                v_count <= v_last ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end else begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end
    end

    assign hSync         = pipe[SYNC_DELAY][2] ^ ~H_POL;
    assign vSync         = pipe[SYNC_DELAY][1] ^ ~V_POL;
    assign displayActive = pipe[SYNC_DELAY][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a tiny 8x6 raster, checking an
// undelayed instance and a two-stage delayed instance side by side.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
        logic       hs;
        logic       vs;
        logic       da;
        logic       hs2;
        logic       vs2;
        logic       da2;
        logic [3:0] col2;
        logic       fs2;
        logic [7:0] fc2;
    } obs_t;

    logic clk   = 1'b0;
    bit   clk_en = 1'b1;
    logic rst   = 1'b1;
    logic pixEn = 1'b0;
    logic run   = 1'b0;

    logic       hs0, vs0, da0, ls0, fs0;
    logic [3:0] col0, row0;
    logic [7:0] fc0;
    logic       hs2, vs2, da2, ls2, fs2;
    logic [3:0] col2, row2;
    logic [7:0] fc2;

    int n_checks = 0;
    int n_fail   = 0;
    obs_t exp_q[$];

    // Reference model state
    int         m_h, m_v;
    logic [7:0] m_fc;
    logic [3:0] m_col, m_row;
    logic       m_ls, m_fs;
    logic [2:0] m_s0, m_s1, m_s2;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .SYNC_DELAY(0), .COL_W(4), .ROW_W(4)
    ) dut0 (
        .clk(clk), .rst(rst), .pixEn(pixEn), .run(run),
        .hSync(hs0), .vSync(vs0), .displayActive(da0),
        .column(col0), .row(row0), .lineStart(ls0), .frameStart(fs0),
        .frameCount(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .SYNC_DELAY(2), .COL_W(4), .ROW_W(4)
    ) dut2 (
        .clk(clk), .rst(rst), .pixEn(pixEn), .run(run),
        .hSync(hs2), .vSync(vs2), .displayActive(da2),
        .column(col2), .row(row2), .lineStart(ls2), .frameStart(fs2),
        .frameCount(fc2)
    );

    function automatic obs_t sample();
        obs_t o;
        o.col = col0;  o.row = row0; o.ls = ls0; o.fs = fs0; o.fc = fc0;
        o.hs = hs0;    o.vs = vs0;   o.da = da0;
        o.hs2 = hs2;   o.vs2 = vs2;  o.da2 = da2;
        o.col2 = col2; o.fs2 = fs2;  o.fc2 = fc2;
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.col = m_col; o.row = m_row; o.ls = m_ls; o.fs = m_fs; o.fc = m_fc;
        o.hs = ~m_s0[2]; o.vs = ~m_s0[1]; o.da = m_s0[0];
        o.hs2 = ~m_s2[2]; o.vs2 = ~m_s2[1]; o.da2 = m_s2[0];
        o.col2 = m_col; o.fs2 = m_fs; o.fc2 = m_fc;
        return o;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_fc = 8'd0; m_col = 4'd0; m_row = 4'd0;
        m_ls = 1'b0; m_fs = 1'b0; m_s0 = 3'b0; m_s1 = 3'b0; m_s2 = 3'b0;
    endtask

    task automatic model_step(input logic p, input logic r);
        if (!r) begin
            m_h = 0; m_v = 0; m_col = 4'd0; m_row = 4'd0; m_ls = 1'b0; m_fs = 1'b0;
            m_s0 = 3'b0; m_s1 = 3'b0; m_s2 = 3'b0;
        end else if (!p) begin
            m_ls = 1'b0; m_fs = 1'b0;
        end else begin
            m_col = 4'(m_h); m_row = 4'(m_v);
            m_ls = (m_h == 0);
            m_fs = (m_h == 0) && (m_v == 0);
            if (m_fs) m_fc = m_fc + 8'd1;
            m_s2 = m_s1; m_s1 = m_s0;
            m_s0 = {(m_h >= 5 && m_h < 7), (m_v == 4), (m_h < 4 && m_v < 3)};
            m_h++;
            if (m_h == 8) begin
                m_h = 0; m_v++;
                if (m_v == 6) m_v = 0;
            end
        end
    endtask

    // Drives one clock of stimulus and queues the model's expectation for it.
    task automatic cycle(input logic p, input logic r);
        pixEn = p; run = r;
        @(posedge clk);
        model_step(p, r);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic test_reset();
        obs_t e, a;
        #2 rst = 1'b0;
        model_reset();
        #1;
        e = model_out(); a = sample();
        n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL reset_values: got %h expected %h", a, e); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        cycle(1'b1, 1'b1);
        e = exp_q.pop_front(); a = sample();
        n_checks++;
        if (a !== e || a.fs !== 1'b1 || a.fc !== 8'd1 || a.col !== 4'd0) begin
            n_fail++; $display("FAIL first_edge_after_reset: got %h expected %h", a, e);
        end
    endtask

    task automatic test_basic_frame();
        obs_t e, a;
        int n_da = 0, last_fs = -1, bad = 0;
        for (int i = 0; i < 96; i++) begin
            cycle(1'b1, 1'b1);
            e = exp_q.pop_front(); a = sample();
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL basic_frame cyc %0d: got %h expected %h", i, a, e); end
            if (i < 48 && a.da) n_da++;
            if (a.fs) begin
                if (last_fs >= 0 && i - last_fs != 48) bad++;
                last_fs = i;
            end
        end
        n_checks++;
        if (n_da != 12) begin n_fail++; $display("FAIL active_pixels: got %0d expected 12", n_da); end
        n_checks++;
        if (bad != 0 || last_fs < 48) begin n_fail++; $display("FAIL frame_period_48: bad %0d last %0d", bad, last_fs); end
    endtask

    task automatic test_pix_enable();
        obs_t e, a;
        int last_fs = -1, bad = 0, pulses = 0;
        for (int i = 0; i < 440; i++) begin
            cycle((i % 3) == 0, 1'b1);
            e = exp_q.pop_front(); a = sample();
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL pix_enable cyc %0d: got %h expected %h", i, a, e); end
            if (a.fs) begin
                pulses++;
                if (last_fs >= 0 && i - last_fs != 144) bad++;
                last_fs = i;
            end
        end
        n_checks++;
        if (bad != 0 || pulses < 3) begin n_fail++; $display("FAIL frame_period_144: bad %0d pulses %0d", bad, pulses); end
    endtask

    task automatic test_sync_delay();
        obs_t e, a;
        for (int i = 0; i < 150; i++) begin
            cycle($urandom_range(0, 1) == 1, 1'b1);
            e = exp_q.pop_front(); a = sample();
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL sync_delay cyc %0d: got %h expected %h", i, a, e); end
        end
    endtask

    task automatic test_frame_count();
        obs_t e, a;
        int k = 0, bad = 0;
        rst = 1'b0; model_reset();
        #2 rst = 1'b1;
        for (int i = 0; i < 256 * 48; i++) begin
            cycle(1'b1, 1'b1);
            e = exp_q.pop_front(); a = sample();
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL frame_count_walk cyc %0d: got %h expected %h", i, a, e); end
            if (a.fs) begin
                k++;
                if (a.fc !== 8'(k)) bad++;
            end
        end
        n_checks++;
        if (k != 256 || bad != 0 || fc0 !== 8'd0) begin
            n_fail++; $display("FAIL frame_count_wrap: frames %0d bad %0d final %0d expected 256/0/0", k, bad, fc0);
        end
    endtask

    task automatic test_run_abort();
        obs_t e, a;
        logic [7:0] fc_before;
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle(1'b1, 1'b1);
            e = exp_q.pop_front(); a = sample();
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL abort_lead cyc %0d: got %h expected %h", i, a, e); end
            if (a.col == 4'd2 && a.row == 4'd1) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL abort_reach_point: row1 col2 not reached within 200 clks"); end
        fc_before = m_fc;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            e = exp_q.pop_front(); a = sample();
            n_checks++;
            if (a !== e || a.col !== 4'd0 || a.hs !== 1'b1 || a.fc !== fc_before) begin
                n_fail++; $display("FAIL abort_idle cyc %0d: got %h expected %h", i, a, e);
            end
        end
        cycle(1'b1, 1'b1);
        e = exp_q.pop_front(); a = sample();
        n_checks++;
        if (a !== e || a.fs !== 1'b1 || a.row !== 4'd0 || a.fc !== fc_before + 8'd1) begin
            n_fail++; $display("FAIL abort_restart: got %h expected %h", a, e);
        end
    endtask

    task automatic test_async_reset();
        obs_t e, a;
        repeat (21) begin
            cycle(1'b1, 1'b1);
            void'(exp_q.pop_front());
        end
        clk_en = 0;
        #3 rst = 1'b0;
        model_reset();
        #1;
        e = model_out(); a = sample();
        n_checks++;
        if (a !== e || a.fc !== 8'd0) begin n_fail++; $display("FAIL async_reset: got %h expected %h", a, e); end
        #4 rst = 1'b1;
        clk_en = 1;
        cycle(1'b1, 1'b1);
        e = exp_q.pop_front(); a = sample();
        n_checks++;
        if (a !== e || a.fs !== 1'b1 || a.fc !== 8'd1) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", a, e);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_frame();
        test_pix_enable();
        test_sync_delay();
        test_frame_count();
        test_run_abort();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameters H_POL and V_POL, default 0, giving the active sync level (0 = active-low).
REQ-010 SHALL have parameter SYNC_DELAY, default 1, range 0-4, pixel-enable stages added to hSync, vSync and displayActive.
REQ-011 SHALL have parameters COL_W, default 10, and ROW_W, default 10, giving counter and output widths, each able to hold total-1.
REQ-012 clk  input  1  single clock; all state changes on its rising edge.
REQ-013 rst  input  1  asynchronous, active-low reset; all state is forced to reset values while low.
REQ-014 pixEn  input  1  pixel-rate enable; timing advances only on clk edges with pixEn=1.
REQ-015 run  input  1  synchronous run control; 0 holds the generator idle.
REQ-016 hSync  output  1  horizontal sync at H_POL level when active.
REQ-017 vSync  output  1  vertical sync at V_POL level when active.
REQ-018 displayActive  output  1  pixel is in the visible region.
REQ-019 column  output  COL_W  current horizontal count, undelayed.
REQ-020 row  output  ROW_W  current vertical count, undelayed.
REQ-021 lineStart  output  1  one-clk pulse at column 0 of every line, undelayed.
REQ-022 frameStart  output  1  one-clk pulse at row 0, column 0, undelayed.
REQ-023 frameCount  output  8  count of frames started, wraps at 255 to 0.

Function
REQ-024 HT = H_ACTIVE+H_FP+H_SYNC+H_BP and VT = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL be the totals; hCount counts 0..HT-1 and vCount counts 0..VT-1.
REQ-025 On a clk edge with pixEn=1 and run=1, outputs SHALL register the decode of the present (hCount, vCount), then hCount SHALL advance; at HT-1, hCount SHALL wrap to 0 and vCount SHALL advance, wrapping from VT-1 to 0.
REQ-026 Decode: active = hCount<H_ACTIVE and vCount<V_ACTIVE; hs = H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC; vs = V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC.
REQ-027 column and row SHALL equal the registered counts; lineStart SHALL be 1 for exactly one clk when the registered hCount is 0; frameStart SHALL do the same when both counts are 0.
REQ-028 frameCount SHALL increment modulo 256 on the same edge that raises frameStart.
REQ-029 hSync, vSync and displayActive SHALL pass through a SYNC_DELAY-deep shift register that advances only on pixEn; with SYNC_DELAY=0 they SHALL be undelayed.
REQ-030 With pixEn=0, every counter, output and delay stage SHALL hold its value, and lineStart and frameStart SHALL be 0.
REQ-031 With run=0 on any clk edge, the counters SHALL clear to 0, the delay stages and outputs SHALL go to reset values, and frameCount SHALL hold its value.
REQ-032 On the first pixEn edge with run=1 after idle or reset, the outputs SHALL be column=0, row=0 and frameStart=1, and frameCount SHALL become its previous value +1.
REQ-033 A run deassertion in the middle of a frame SHALL abort that frame with no partial-line completion.

Reset
REQ-034 While rst=0: hCount=0, vCount=0, column=0, row=0, frameCount=0, lineStart=0, frameStart=0, displayActive=0, hSync=!H_POL, vSync=!V_POL, and all delay stages hold these inactive values.
REQ-035 Release of rst SHALL take effect on the first clk edge after the release, with no other recovery cycles.

Verification
REQ-036 Params H 4/1/2/1, V 3/1/1/1, SYNC_DELAY=0, pixEn=1, run=1 -> hSync low at columns 5-6, vSync low at row 4, displayActive for 12 pixels per frame, frameStart every 48 clks.
REQ-037 Same params with pixEn=1 every third clk -> frameStart every 144 clks, each pulse exactly 1 clk wide.
REQ-038 SYNC_DELAY=2 -> hSync, vSync and displayActive lag the SYNC_DELAY=0 waveform by exactly 2 pixEn edges; column, row and frameStart unchanged.
REQ-039 Run 256 frames -> frameCount goes 1..255 then 0 on the 256th frameStart.
REQ-040 Drop run at row 1, column 2 for 3 clks, then raise it -> outputs idle while run=0; next pixEn edge gives column=0, row=0, frameStart=1, frameCount +1.
REQ-041 Assert rst mid-frame with clk stopped -> outputs take reset values at once; frameCount=0.
